// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: two result queues (ALU, LSB) drained round-robin onto a registered CDB.
// Optional same-cycle bypass of a push into an empty queue when CDB_BYPASS_EN is defined.
module cdb_arbiter #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned TAG_W  = 4,
    parameter int unsigned DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              jump_wrong,
    input  logic              alu_push,
    input  logic [TAG_W-1:0]  alu_tag,
    input  logic [DATA_W-1:0] alu_value,
    input  logic              lsb_push,
    input  logic [TAG_W-1:0]  lsb_tag,
    input  logic [DATA_W-1:0] lsb_value,
    output logic              alu_stall,
    output logic              lsb_stall,
    output logic              cdb_valid,
    output logic [TAG_W-1:0]  cdb_tag,
    output logic [DATA_W-1:0] cdb_value,
    output logic              cdb_src,
    output logic              overflow_err
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [TAG_W-1:0]  tag;
        logic [DATA_W-1:0] value;
    } ent_t;

    ent_t             qa_mem [DEPTH];
    ent_t             ql_mem [DEPTH];
    logic [PTR_W-1:0] qa_rd, qa_wr, ql_rd, ql_wr;
    logic [CNT_W-1:0] qa_cnt, ql_cnt;
    logic             rr;

    ent_t alu_ent, lsb_ent, gnt_ent;
    logic qa_ne, ql_ne, a_byp, l_byp, a_req, l_req;
    logic gnt_a, gnt_l, pop_a, pop_l, wr_a, wr_l, drop_a, drop_l;

    assign alu_ent   = '{tag: alu_tag, value: alu_value};
    assign lsb_ent   = '{tag: lsb_tag, value: lsb_value};
    assign alu_stall = qa_cnt >= CNT_W'(DEPTH - 1);
    assign lsb_stall = ql_cnt >= CNT_W'(DEPTH - 1);

    // Request, grant, pop and enqueue decisions for this cycle
    always_comb begin
        qa_ne = qa_cnt != '0;
        ql_ne = ql_cnt != '0;
`ifdef CDB_BYPASS_EN
        a_byp = alu_push && !qa_ne;
        l_byp = lsb_push && !ql_ne;
`else
        a_byp = 1'b0;
        l_byp = 1'b0;
`endif
        a_req   = qa_ne || a_byp;
        l_req   = ql_ne || l_byp;
        gnt_a   = a_req && (!l_req || !rr);
        gnt_l   = l_req && !gnt_a;
        pop_a   = gnt_a && qa_ne;
        pop_l   = gnt_l && ql_ne;
        // A granted bypass consumes the push; otherwise it competes for a slot
        wr_a    = alu_push && !(gnt_a && !qa_ne) && ((qa_cnt != CNT_W'(DEPTH)) || pop_a);
        wr_l    = lsb_push && !(gnt_l && !ql_ne) && ((ql_cnt != CNT_W'(DEPTH)) || pop_l);
        drop_a  = alu_push && (qa_cnt == CNT_W'(DEPTH)) && !pop_a;
        drop_l  = lsb_push && (ql_cnt == CNT_W'(DEPTH)) && !pop_l;
        gnt_ent = gnt_a ? (qa_ne ? qa_mem[qa_rd] : alu_ent)
                        : (ql_ne ? ql_mem[ql_rd] : lsb_ent);
    end

    // Queue storage carries no reset; pointers and counts define validity
    always_ff @(posedge clk) begin
        if (rdy && !jump_wrong) begin
            if (wr_a) qa_mem[qa_wr] <= alu_ent;
            if (wr_l) ql_mem[ql_wr] <= lsb_ent;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            qa_rd        <= '0;
            qa_wr        <= '0;
            ql_rd        <= '0;
            ql_wr        <= '0;
            qa_cnt       <= '0;
            ql_cnt       <= '0;
            rr           <= 1'b0;
            cdb_valid    <= 1'b0;
            cdb_tag      <= '0;
            cdb_value    <= '0;
            cdb_src      <= 1'b0;
            overflow_err <= 1'b0;
        end else if (rdy) begin
            if (jump_wrong) begin
                qa_rd     <= '0;
                qa_wr     <= '0;
                ql_rd     <= '0;
                ql_wr     <= '0;
                qa_cnt    <= '0;
                ql_cnt    <= '0;
                rr        <= 1'b0;
                cdb_valid <= 1'b0;
            end else begin
                if (wr_a)  qa_wr <= qa_wr + PTR_W'(1);
                if (pop_a) qa_rd <= qa_rd + PTR_W'(1);
                if (wr_l)  ql_wr <= ql_wr + PTR_W'(1);
                if (pop_l) ql_rd <= ql_rd + PTR_W'(1);
                qa_cnt <= qa_cnt + CNT_W'(wr_a) - CNT_W'(pop_a);
                ql_cnt <= ql_cnt + CNT_W'(wr_l) - CNT_W'(pop_l);
                if (drop_a || drop_l) overflow_err <= 1'b1;
                cdb_valid <= gnt_a || gnt_l;
                if (gnt_a || gnt_l) begin
                    cdb_tag   <= gnt_ent.tag;
                    cdb_value <= gnt_ent.value;
                    cdb_src   <= gnt_l;
                    rr        <= gnt_a;
                end
            end
        end
    end
endmodule

// File: tb/tb_cdb_arbiter.sv
// Self-checking bench for cdb_arbiter: queue-level reference model compared every cycle,
// plus directed scenarios with literal expectations.
module tb_cdb_arbiter;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned TAG_W  = 4;
    localparam int unsigned DEPTH  = 4;
`ifdef CDB_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst, rdy, jump_wrong, alu_push, lsb_push;
    logic [TAG_W-1:0]  alu_tag, lsb_tag;
    logic [DATA_W-1:0] alu_value, lsb_value;
    logic              alu_stall, lsb_stall, cdb_valid, cdb_src, overflow_err;
    logic [TAG_W-1:0]  cdb_tag;
    logic [DATA_W-1:0] cdb_value;

    cdb_arbiter #(.DATA_W(DATA_W), .TAG_W(TAG_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .rdy(rdy), .jump_wrong(jump_wrong),
        .alu_push(alu_push), .alu_tag(alu_tag), .alu_value(alu_value),
        .lsb_push(lsb_push), .lsb_tag(lsb_tag), .lsb_value(lsb_value),
        .alu_stall(alu_stall), .lsb_stall(lsb_stall),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
        .cdb_src(cdb_src), .overflow_err(overflow_err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;
    bit cmp_en = 1'b0;
    logic rdy_s;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        else n_pass++;
    endtask

    // Reference model: two FIFOs of {tag,value}, a preference bit, sticky overflow
    logic [TAG_W+DATA_W-1:0] mqa[$];
    logic [TAG_W+DATA_W-1:0] mql[$];
    bit                mrr = 1'b0, mov = 1'b0, mv = 1'b0, msrc = 1'b0;
    logic [TAG_W-1:0]  mtag = '0;
    logic [DATA_W-1:0] mval = '0;

    always @(posedge clk or posedge rst) begin : model
        logic [TAG_W+DATA_W-1:0] e, ea, el;
        bit an, ln, ab, lb, a_used, l_used;
        int g;
        if (rst) begin
            mqa.delete(); mql.delete();
            mrr = 0; mov = 0; mv = 0; msrc = 0; mtag = '0; mval = '0;
        end else if (rdy) begin
            if (jump_wrong) begin
                mqa.delete(); mql.delete();
                mv = 0; mrr = 0;
            end else begin
                ea = {alu_tag, alu_value};
                el = {lsb_tag, lsb_value};
                e  = '0;
                an = mqa.size() > 0;
                ln = mql.size() > 0;
                ab = 0; lb = 0;
`ifdef CDB_BYPASS_EN
                ab = alu_push && !an;
                lb = lsb_push && !ln;
`endif
                g = -1;
                if ((an || ab) && (ln || lb)) g = mrr ? 1 : 0;
                else if (an || ab) g = 0;
                else if (ln || lb) g = 1;
                a_used = 0; l_used = 0;
                if (g == 0) begin
                    if (an) e = mqa.pop_front(); else begin e = ea; a_used = 1; end
                    msrc = 0; mrr = 1;
                end else if (g == 1) begin
                    if (ln) e = mql.pop_front(); else begin e = el; l_used = 1; end
                    msrc = 1; mrr = 0;
                end
                mv = (g >= 0);
                if (g >= 0) begin
                    mtag = e[DATA_W +: TAG_W];
                    mval = e[DATA_W-1:0];
                end
                if (alu_push && !a_used) begin
                    if (mqa.size() < DEPTH) mqa.push_back(ea); else mov = 1;
                end
                if (lsb_push && !l_used) begin
                    if (mql.size() < DEPTH) mql.push_back(el); else mov = 1;
                end
            end
        end
    end

    always @(posedge clk) rdy_s <= rdy;

    // Broadcast log of {src,tag} for live (non-frozen) cycles
    logic [4:0] log_q[$];

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("cdb_valid", 64'(cdb_valid), 64'(mv));
            chk("cdb_tag", 64'(cdb_tag), 64'(mtag));
            chk("cdb_value", 64'(cdb_value), 64'(mval));
            chk("cdb_src", 64'(cdb_src), 64'(msrc));
            chk("alu_stall", 64'(alu_stall), 64'(mqa.size() >= DEPTH - 1));
            chk("lsb_stall", 64'(lsb_stall), 64'(mql.size() >= DEPTH - 1));
            chk("overflow_err", 64'(overflow_err), 64'(mov));
            if (cdb_valid && rdy_s) log_q.push_back({cdb_src, cdb_tag});
        end
    end

    task automatic cyc(input logic ap, input logic [TAG_W-1:0] at, input logic [DATA_W-1:0] av,
                       input logic lp, input logic [TAG_W-1:0] lt, input logic [DATA_W-1:0] lv,
                       input logic jw, input logic r);
        @(negedge clk);
        #1;
        alu_push = ap; alu_tag = at; alu_value = av;
        lsb_push = lp; lsb_tag = lt; lsb_value = lv;
        jump_wrong = jw; rdy = r;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(0, '0, '0, 0, '0, '0, 0, 1);
    endtask

    task automatic flush();
        cyc(0, '0, '0, 0, '0, '0, 1, 1);
    endtask

    logic [4:0] exp_rr [6];
    logic [4:0] exp_fr [4];
    logic [4:0] ent;
    logic       snap_v, snap_s;
    logic [TAG_W-1:0]  snap_t;
    logic [DATA_W-1:0] snap_d;
    int na, nl;

    initial begin
        exp_rr = '{5'h01, 5'h19, 5'h02, 5'h1A, 5'h03, 5'h1B};
        exp_fr = '{5'h01, 5'h11, 5'h02, 5'h12};
        rst = 1'b1; rdy = 1'b1; jump_wrong = 1'b0;
        alu_push = 1'b0; alu_tag = '0; alu_value = '0;
        lsb_push = 1'b0; lsb_tag = '0; lsb_value = '0;
        @(negedge clk);
        #1;
        chk("rst_valid", 64'(cdb_valid), 64'd0);
        chk("rst_tag", 64'(cdb_tag), 64'd0);
        chk("rst_value", 64'(cdb_value), 64'd0);
        chk("rst_src", 64'(cdb_src), 64'd0);
        chk("rst_alu_stall", 64'(alu_stall), 64'd0);
        chk("rst_lsb_stall", 64'(lsb_stall), 64'd0);
        chk("rst_overflow", 64'(overflow_err), 64'd0);
        rst = 1'b0;
        cmp_en = 1'b1;

        // Single ALU push: tag 3, value 0x1234
        log_q.delete();
        cyc(1, 4'd3, 32'h1234, 0, '0, '0, 0, 1);
        idle(1);
        chk("single_after_e0", 64'(cdb_valid), 64'(BYP));
        idle(1);
        chk("single_after_e1", 64'(cdb_valid), 64'(!BYP));
        idle(2);
        chk("single_idle_valid", 64'(cdb_valid), 64'd0);
        chk("single_held_tag", 64'(cdb_tag), 64'd3);
        chk("single_held_value", 64'(cdb_value), 64'h1234);
        chk("single_count", 64'(log_q.size()), 64'd1);
        if (log_q.size() > 0) chk("single_entry", 64'(log_q[0]), 64'h03);

        // Round-robin from a flushed (ALU-preferred) state
        flush();
        log_q.delete();
        for (int i = 0; i < 3; i++)
            cyc(1, TAG_W'(i + 1), 32'hA0 + 32'(i), 1, TAG_W'(9 + i), 32'hB0 + 32'(i), 0, 1);
        idle(8);
        chk("rr_count", 64'(log_q.size()), 64'd6);
        for (int i = 0; i < 6; i++)
            if (i < log_q.size()) chk("rr_seq", 64'(log_q[i]), 64'(exp_rr[i]));

        // Saturate both queues until pushes are dropped
        flush();
        log_q.delete();
        for (int k = 0; k < 9; k++) begin
            cyc(1, TAG_W'(k + 1), 32'h100 + 32'(k), 1, TAG_W'(k), 32'h200 + 32'(k), 0, 1);
`ifndef CDB_BYPASS_EN
            if (k == 4) begin
                chk("full_alu_stall_cnt2", 64'(alu_stall), 64'd0);
                chk("full_lsb_stall_cnt3", 64'(lsb_stall), 64'd1);
            end
            if (k == 5) chk("full_alu_stall_cnt3", 64'(alu_stall), 64'd1);
            if (k == 7) chk("full_ovf_before", 64'(overflow_err), 64'd0);
            if (k == 8) chk("full_ovf_after", 64'(overflow_err), 64'd1);
`endif
        end
        idle(12);
        na = 0; nl = 0;
        for (int i = 0; i < log_q.size(); i++) begin
            ent = log_q[i];
            if (ent[4] == 1'b0) begin
                chk("full_alu_order", 64'(ent[3:0]), 64'(na + 1));
                na++;
            end else begin
`ifndef CDB_BYPASS_EN
                chk("full_lsb_order", 64'(ent[3:0]), 64'((nl == 7) ? 8 : nl));
`endif
                nl++;
            end
        end
`ifndef CDB_BYPASS_EN
        chk("full_alu_total", 64'(na), 64'd8);
        chk("full_lsb_total", 64'(nl), 64'd8);
`endif

        // Flush with queued entries and a concurrent LSB push
        flush();
        for (int i = 0; i < 3; i++)
            cyc(1, TAG_W'(i + 1), 32'hC0 + 32'(i), 1, TAG_W'(i + 1), 32'hD0 + 32'(i), 0, 1);
        cyc(0, '0, '0, 1, 4'd7, 32'h77, 1, 1);
        log_q.delete();
        idle(1);
        chk("flush_valid", 64'(cdb_valid), 64'd0);
        chk("flush_alu_stall", 64'(alu_stall), 64'd0);
        chk("flush_lsb_stall", 64'(lsb_stall), 64'd0);
        chk("flush_ovf_kept", 64'(overflow_err), 64'd1);
        idle(5);
        chk("flush_no_bcast", 64'(log_q.size()), 64'd0);

        // rdy freeze with entries queued, then resume in order
        log_q.delete();
        cyc(1, 4'd1, 32'h11, 1, 4'd1, 32'h21, 0, 1);
        cyc(1, 4'd2, 32'h12, 1, 4'd2, 32'h22, 0, 1);
        cyc(0, '0, '0, 0, '0, '0, 0, 0);
        snap_v = cdb_valid; snap_t = cdb_tag; snap_d = cdb_value; snap_s = cdb_src;
        chk("freeze_start_valid", 64'(snap_v), 64'd1);
        for (int i = 0; i < 5; i++) begin
            cyc(0, '0, '0, 0, '0, '0, 0, 0);
            chk("freeze_valid", 64'(cdb_valid), 64'(snap_v));
            chk("freeze_tag", 64'(cdb_tag), 64'(snap_t));
            chk("freeze_value", 64'(cdb_value), 64'(snap_d));
            chk("freeze_src", 64'(cdb_src), 64'(snap_s));
        end
        idle(8);
        chk("freeze_count", 64'(log_q.size()), 64'd4);
        for (int i = 0; i < 4; i++)
            if (i < log_q.size()) chk("freeze_seq", 64'(log_q[i]), 64'(exp_fr[i]));

        // Asynchronous reset while a broadcast is on the bus
        cyc(1, 4'd5, 32'h55, 0, '0, '0, 0, 1);
        for (int i = 0; i < 4 && !cdb_valid; i++) idle(1);
        chk("arst_pre_valid", 64'(cdb_valid), 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_valid", 64'(cdb_valid), 64'd0);
        chk("arst_tag", 64'(cdb_tag), 64'd0);
        chk("arst_value", 64'(cdb_value), 64'd0);
        chk("arst_overflow", 64'(overflow_err), 64'd0);
        @(negedge clk);
        #1 rst = 1'b0;
        idle(3);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end
endmodule

// File: doc/cdb_arbiter.md
# cdb_arbiter

Shares the single common data bus (CDB) between the ALU and the load/store buffer (LSB), the two producers of speculative results. Each producer pushes {ROB tag, value} into its own small queue. A round-robin arbiter drains one entry per cycle onto a registered CDB that the reservation station, LSB and ROB snoop. Mispredict flush empties both queues. Backpressure goes to the RS issue logic and to the LSB.

## Interface
- DATA_W, 32, result value width
- TAG_W, 4, ROB index width
- DEPTH, 4, entries per source queue (power of two, ≥2)
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- rdy  in  1  global enable; 0 freezes all state
- jump_wrong  in  1  mispredict flush, synchronous
- alu_push  in  1  ALU result valid
- alu_tag  in  TAG_W  ROB index of ALU result
- alu_value  in  DATA_W  ALU result
- lsb_push  in  1  load result valid
- lsb_tag  in  TAG_W  ROB index of load
- lsb_value  in  DATA_W  load data
- alu_stall  out  1  ALU queue nearly full; RS must not issue
- lsb_stall  out  1  LSB queue nearly full; LSB must not complete loads
- cdb_valid  out  1  broadcast valid
- cdb_tag  out  TAG_W  broadcast ROB index
- cdb_value  out  DATA_W  broadcast value
- cdb_src  out  1  0 = ALU, 1 = LSB
- overflow_err  out  1  sticky: a push was dropped on a full queue

## Operation
- Two independent circular queues, qa (ALU) and ql (LSB). Each has rd/wr pointers of log2(DEPTH) bits, wrapping naturally, and a count of log2(DEPTH)+1 bits.
- Push accepted if count < DEPTH, or count == DEPTH with a pop of that queue in the same cycle.
  - A push on a full queue with no pop is dropped and sets overflow_err.
- Simultaneous push and pop on one queue leaves count unchanged.
- Stall: x_stall = (count_x ≥ DEPTH−1), combinational from count. This leaves one slot for a result already in flight.
- Arbitration state rr: 0 = ALU preferred, 1 = LSB preferred.
  - Both queues non-empty: grant the rr source, then rr ← other source.
  - One queue non-empty: grant it, then rr ← other source.
  - Neither non-empty: no grant, rr unchanged.
- Output register, updated each rdy cycle:
  - On a grant, cdb_valid←1 and cdb_tag/cdb_value/cdb_src←head of the granted queue, which is popped.
  - With no grant, cdb_valid←0; tag, value and src hold their last values.
- The CDB has no backpressure; a grant is one broadcast, one cycle.
- Flush (jump_wrong=1, rdy=1): both queues emptied (pointers and counts ← 0), cdb_valid←0, rr←0.
  - Pushes in the flush cycle are dropped and do not set overflow_err.
  - overflow_err is preserved.
- rdy=0: no pushes, pops, grants or flush; every register holds. Upstream producers are gated by the same rdy.
- Priority: rst > jump_wrong > normal operation.

## Timing
- Reset values: cdb_valid=0, cdb_tag=0, cdb_value=0, cdb_src=0, overflow_err=0, rr=0, all counts/pointers 0. This gives alu_stall=0 and lsb_stall=0.
- Reset is asynchronous: outputs clear immediately on rst rising, including mid-broadcast. Queue contents are discarded.
- Latency without bypass: push sampled at edge N → entry visible in queue after N → granted and cdb_valid high after edge N+1 (2 cycles).
- Sustained throughput: one broadcast per cycle total.
- With both sources saturated, ALU and LSB alternate every cycle.
- Stall asserts in the same cycle count reaches DEPTH−1 and deasserts the cycle after it drops below.

## Configuration
- CDB_BYPASS_EN defined:
  - A push into an empty queue may be granted in its own cycle. Arbitration treats that queue as non-empty, using the push data as head; the entry never occupies a slot.
  - Latency is 1 cycle (push at edge N, cdb_valid after edge N). rr rules are unchanged.
  - A bypassed push that loses arbitration is enqueued normally.
- Not defined: every entry passes through its queue; latency is fixed at 2 cycles. Port list is identical in both builds.

## Test plan
- **Single ALU push:** alu_push with tag=3, value=0x1234 at edge 0 → cdb_valid=1, cdb_tag=3, cdb_value=0x1234, cdb_src=0 after edge 1 (after edge 0 with CDB_BYPASS_EN). Then cdb_valid=0.
- **Round-robin:** push ALU tags 1,2,3 and LSB tags 9,10,11 on the same three cycles → CDB sequence 1,9,2,10,3,11, with cdb_src alternating 0,1.
- **Full/stall with DEPTH=4:** push 3 ALU entries while LSB keeps winning → alu_stall=1 at count 3. A 5th push with no pop is dropped, overflow_err=1, and the 4 queued tags broadcast intact in order.
- **Flush:** 2 entries queued in each queue, jump_wrong=1 for one cycle with a concurrent lsb_push → cdb_valid=0 next cycle, both stalls 0, no further broadcasts, overflow_err unchanged.
- **rdy freeze and async reset:** hold rdy=0 for 5 cycles with 2 entries queued → outputs frozen; on rdy=1 broadcasts resume in order. Assert rst mid-cycle while cdb_valid=1 → cdb_valid=0 before the next clock edge.
